sram_mem_responder: RTL and testbench

//  Memory-side responder for the MEM stage: services one 32-bit word read/write per request on an external
//  16-bit asynchronous SRAM as two half-word accesses. Replaces the single-cycle DataMemory.

---
 rtl/sram_mem_responder_pkg.sv | 52 +++++
 rtl/sram_mem_responder_if.sv | 45 ++++
 rtl/sram_mem_responder.sv | 178 +++++++++++++++++
 tb/tb_sram_mem_responder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// sram_mem_responder_pkg
//
// Shared definitions for the MEM-stage SRAM responder:
//   - default mapping/timing parameters (base address, SRAM address width,
//     cycles per half-word access)
//   - datapath widths and access-counter width
//   - FSM state encoding (2 bit) and the latched operation type
//   - a helper that decides the write strobe level for a given access cycle
// ---------------------------------------------------------------------------
package sram_mem_responder_pkg;

    // Byte address that maps onto SRAM half-word 0.
    localparam logic [31:0] DEF_BASE_ADDR  = 32'd1024;

    // SRAM address width, counted in half-words.
    localparam int          DEF_SRAM_AW    = 18;

    // Cycles spent on each half-word access (legal range 2..15).
    localparam int          DEF_ACCESS_CYC = 2;

    localparam int          DATA_W         = 32;
    localparam int          HALF_W         = 16;

    // Wide enough for the largest legal ACCESS_CYC of 15.
    localparam int          CNT_W          = 4;

    // Transaction phases. ACC_LO / ACC_HI each cover one half-word access.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_LO = 2'd1,
        ACC_HI = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Operation latched at the start of a transaction.
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // Active-low write strobe level for the access cycle being entered.
    // The strobe is held low for every cycle except the last one of each
    // half-word access; that last cycle keeps data on the bus with the
    // strobe released so the SRAM sees a clean data hold after the edge.
    function automatic logic we_strobe_n(input op_t              op,
                                         input logic [CNT_W-1:0] cnt_next,
                                         input logic [CNT_W-1:0] last_cnt);
        return !((op == OP_WRITE) && (cnt_next < last_cnt));
    endfunction

endpackage

// File: rtl/sram_mem_responder_if.sv
// ---------------------------------------------------------------------------
// sram_mem_responder_if
//
// Request/response bundle between the MEM pipeline stage and the SRAM
// responder.
//   rd_en       pipeline -> responder   load request, held until ready
//   wr_en       pipeline -> responder   store request, held until ready
//   address     pipeline -> responder   byte address (ALU result)
//   write_data  pipeline -> responder   store data
//   read_data   responder -> pipeline   load data of the last completed read
//   ready       responder -> pipeline   0 freezes the whole pipeline
//
// Modports:
//   master  the pipeline side (drives requests)
//   slave   the responder side (answers with ready/read_data)
// ---------------------------------------------------------------------------
interface sram_mem_responder_if;
    import sram_mem_responder_pkg::*;

    logic              rd_en;
    logic              wr_en;
    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              ready;

    modport master (
        output rd_en,
        output wr_en,
        output address,
        output write_data,
        input  read_data,
        input  ready
    );

    modport slave (
        input  rd_en,
        input  wr_en,
        input  address,
        input  write_data,
        output read_data,
        output ready
    );

endinterface

// File: rtl/sram_mem_responder.sv
// ---------------------------------------------------------------------------
// sram_mem_responder
//
// Memory-side responder for the MEM stage. Each 32-bit load/store request is
// serviced on an external 16-bit asynchronous SRAM as two half-word accesses
// (low half first, then high half). The pipeline is stalled through 'ready'
// while the transaction is in flight.
//
// Parameters:
//   BASE_ADDR   byte address mapped to SRAM half-word 0
//   SRAM_AW     SRAM address width in half-words
//   ACCESS_CYC  cycles per half-word access, legal range 2..15
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-low reset
//   bus          request/response interface (slave modport)
//   sram_addr    SRAM half-word address (registered)
//   sram_dq_out  SRAM write data (registered)
//   sram_dq_in   SRAM read data
//   sram_dq_oe   1 = drive sram_dq_out onto the shared data bus (registered)
//   sram_we_n    SRAM write strobe, active-low (registered)
//   sram_oe_n    SRAM output enable, active-low (registered)
//
// The bidirectional data-bus buffer lives in the chip top level and is
// controlled by sram_dq_oe.
// ---------------------------------------------------------------------------
module sram_mem_responder
    import sram_mem_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int          SRAM_AW    = DEF_SRAM_AW,
    parameter int          ACCESS_CYC = DEF_ACCESS_CYC
) (
    input  logic               clk,
    input  logic               rst,
    sram_mem_responder_if.slave bus,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [HALF_W-1:0]  sram_dq_out,
    input  logic [HALF_W-1:0]  sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    // One SRAM word is two half-words, so the word index is one bit
    // narrower than the half-word address.
    localparam int               WORD_W   = SRAM_AW - 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYC - 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    op_t                 op;
    logic [WORD_W-1:0]   word;
    logic [DATA_W-1:0]   wdata;
    logic [HALF_W-1:0]   lo_half;
    logic [DATA_W-1:0]   read_data_q;

    logic                req;
    op_t                 req_op;
    logic [DATA_W-1:0]   offset;
    logic [WORD_W-1:0]   req_word;
    logic [CNT_W-1:0]    cnt_inc;

    // Request decode. A store wins when both enables are raised together.
    // The offset from the base address wraps modulo 2^32 and the word
    // index simply keeps the low bits of offset/4, so addresses outside
    // the SRAM window alias onto it without any range check.
    assign req      = bus.rd_en || bus.wr_en;
    assign req_op   = bus.wr_en ? OP_WRITE : OP_READ;
    assign offset   = bus.address - BASE_ADDR;
    assign req_word = WORD_W'(offset >> 2);
    assign cnt_inc  = cnt + 1'b1;

    // The pipeline may advance whenever nothing is pending in IDLE, or in
    // the single DONE cycle that closes a transaction. A request sitting in
    // IDLE holds ready low for that cycle because it is about to start.
    assign bus.ready     = (state == DONE) || ((state == IDLE) && !req);
    assign bus.read_data = read_data_q;

    // Transaction FSM with registered SRAM strobes.
    // Every SRAM output is loaded with the value belonging to the state
    // (and counter value) being entered, so the strobes never come from
    // combinational logic. The request fields are captured once in IDLE
    // and never re-sampled, which lets a flushed request run to DONE
    // without tearing a store. read_data only changes on the edge that
    // enters DONE, so a reset in the middle of a read cannot leave a
    // half-updated word behind.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op          <= OP_READ;
            word        <= '0;
            wdata       <= '0;
            lo_half     <= '0;
            read_data_q <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state      <= ACC_LO;
                        cnt        <= '0;
                        op         <= req_op;
                        word       <= req_word;
                        wdata      <= bus.write_data;
                        sram_addr  <= {req_word, 1'b0};
                        sram_we_n  <= we_strobe_n(req_op, '0, LAST_CNT);
                        if (req_op == OP_WRITE) begin
                            sram_dq_oe  <= 1'b1;
                            sram_dq_out <= bus.write_data[HALF_W-1:0];
                            sram_oe_n   <= 1'b1;
                        end else begin
                            sram_dq_oe  <= 1'b0;
                            sram_oe_n   <= 1'b0;
                        end
                    end
                end

                ACC_LO: begin
                    if (cnt != LAST_CNT) begin
                        cnt       <= cnt_inc;
                        sram_we_n <= we_strobe_n(op, cnt_inc, LAST_CNT);
                    end else begin
                        // The SRAM has had the whole access window to
                        // settle, so the low half is captured here.
                        if (op == OP_READ) begin
                            lo_half <= sram_dq_in;
                        end
                        state     <= ACC_HI;
                        cnt       <= '0;
                        sram_addr <= {word, 1'b1};
                        sram_we_n <= we_strobe_n(op, '0, LAST_CNT);
                        if (op == OP_WRITE) begin
                            sram_dq_out <= wdata[DATA_W-1:HALF_W];
                        end
                    end
                end

                ACC_HI: begin
                    if (cnt != LAST_CNT) begin
                        cnt       <= cnt_inc;
                        sram_we_n <= we_strobe_n(op, cnt_inc, LAST_CNT);
                    end else begin
                        if (op == OP_READ) begin
                            read_data_q <= {sram_dq_in, lo_half};
                        end
                        state      <= DONE;
                        cnt        <= '0;
                        sram_we_n  <= 1'b1;
                        sram_oe_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                    end
                end

                DONE: begin
                    // Any request still present is only looked at again
                    // from IDLE, where it becomes a fresh transaction.
                    state <= IDLE;
                end

                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    sram_we_n  <= 1'b1;
                    sram_oe_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_sram_mem_responder
//
// Bench for the MEM-stage SRAM responder. A behavioural 16-bit SRAM hangs
// off the SRAM pins. The driver issues requests and pushes the expected
// completion (latency and read_data) plus the expected half-word writes
// into queues; a separate monitor pops and compares whenever the DUT
// completes a transaction or releases a write strobe. The reference model
// is a word-addressed associative array computed from the address mapping
// rules directly.
// ---------------------------------------------------------------------------
module tb_sram_mem_responder;

    localparam logic [31:0] BASE  = 32'd1024;
    localparam int          AW    = 18;
    localparam int          AC    = 2;
    localparam int unsigned WORDS = 1 << (AW - 1);
    localparam int          LAT   = 2 * AC + 1;

    typedef struct {
        bit          is_read;
        logic [31:0] exp_rd;
        int          issue_cycle;
    } txn_exp_t;

    typedef struct {
        int unsigned addr;
        logic [15:0] data;
    } wev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic [15:0]   sram_dq_in;
    logic          sram_dq_oe;
    logic          sram_we_n;
    logic          sram_oe_n;

    sram_mem_responder_if mif();

    sram_mem_responder #(
        .BASE_ADDR (BASE),
        .SRAM_AW   (AW),
        .ACCESS_CYC(AC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (mif),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in (sram_dq_in),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n)
    );

    always #5 clk = ~clk;

    int          cycle_count = 0;
    int          checks      = 0;
    int          fails       = 0;
    int          done_count  = 0;
    bit          sb_skip     = 1'b0;
    logic [31:0] model_rd    = 32'h0;

    txn_exp_t    exp_q[$];
    wev_t        wev_q[$];
    logic [31:0] ref_mem[int unsigned];
    logic [15:0] sram_mem[0:(1<<AW)-1];

    // Cycle numbering: the cycle after posedge N is cycle N.
    always @(posedge clk) cycle_count <= cycle_count + 1;

    // Behavioural asynchronous SRAM: writes while the strobe is low with the
    // bus driven, reads whenever the output enable is low.
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;
    end
    assign sram_dq_in = sram_oe_n ? 16'h0000 : sram_mem[sram_addr];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cycle_count);
        end
    endtask

    // Reference behaviour of one request: stores update the word model and
    // produce two half-word writes, loads return the stored word (0 if never
    // written), and read_data only changes on loads.
    task automatic push_expect(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [31:0] data, input int issue);
        txn_exp_t    e;
        logic [31:0] off;
        int unsigned w;
        off = addr - BASE;
        w   = (off >> 2) % WORDS;
        e.issue_cycle = issue;
        if (wr) begin
            ref_mem[w] = data;
            wev_q.push_back('{2 * w,     data[15:0]});
            wev_q.push_back('{2 * w + 1, data[31:16]});
            e.is_read = 1'b0;
        end else if (rd) begin
            model_rd  = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
            e.is_read = 1'b1;
        end
        e.exp_rd = model_rd;
        exp_q.push_back(e);
    endtask

    // Returns just after the posedge that follows the completion cycle.
    task automatic wait_done(input int target);
        int n = 0;
        while (done_count < target && n < 4 * LAT) begin
            @(posedge clk);
            n++;
        end
        if (done_count < target) begin
            checks++;
            fails++;
            $display("[TB] FAIL timeout: completions %0d expected %0d", done_count, target);
        end
    endtask

    task automatic drop_request();
        mif.rd_en      = 1'b0;
        mif.wr_en      = 1'b0;
        mif.address    = $urandom;
        mif.write_data = $urandom;
    endtask

    // One transaction from IDLE. With flush set the request is removed (and
    // the address/data scrambled) one cycle after it was accepted.
    task automatic apply_stimulus(input bit rd, input bit wr, input logic [31:0] addr,
                                  input logic [31:0] data, input bit flush);
        int target;
        @(posedge clk); #1;
        target         = done_count + 1;
        mif.rd_en      = rd;
        mif.wr_en      = wr;
        mif.address    = addr;
        mif.write_data = data;
        push_expect(rd, wr, addr, data, cycle_count);
        if (flush) begin
            @(posedge clk); #1;
            drop_request();
        end
        wait_done(target);
        #1;
        drop_request();
    endtask

    // Monitor: a rising 'ready' marks a DONE cycle; a rising write strobe
    // marks a completed half-word write.
    initial begin
        bit       prev_ready = 1'b1;
        bit       prev_we_n  = 1'b1;
        int       we_low     = 0;
        txn_exp_t e;
        wev_t     w;
        forever begin
            @(negedge clk);
            if (sb_skip || !rst) begin
                prev_ready = mif.ready;
                prev_we_n  = sram_we_n;
                we_low     = 0;
                continue;
            end
            if (mif.ready && !prev_ready) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_done", 32'(cycle_count), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_output("latency", 32'(cycle_count - e.issue_cycle), 32'(LAT));
                    check_output(e.is_read ? "read_data" : "read_data_kept", mif.read_data, e.exp_rd);
                end
                done_count++;
            end
            if (!sram_we_n) we_low++;
            if (sram_we_n && !prev_we_n) begin
                if (wev_q.size() == 0) begin
                    check_output("unexpected_write", 32'(sram_addr), 32'hFFFF_FFFF);
                end else begin
                    w = wev_q.pop_front();
                    check_output("wr_addr", 32'(sram_addr), w.addr);
                    check_output("wr_data", 32'(sram_dq_out), 32'(w.data));
                    check_output("wr_drive", 32'(sram_dq_oe), 32'd1);
                    check_output("we_low_cycles", 32'(we_low), 32'(AC - 1));
                end
                we_low = 0;
            end
            prev_ready = mif.ready;
            prev_we_n  = sram_we_n;
        end
    end

    initial begin
        int target;
        for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 16'h0000;
        rst = 1'b0;
        drop_request();
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] reset state");
        check_output("rst_ready",     32'(mif.ready),   32'd1);
        check_output("rst_read_data", mif.read_data,    32'h0);
        check_output("rst_sram_addr", 32'(sram_addr),   32'h0);
        check_output("rst_dq_out",    32'(sram_dq_out), 32'h0);
        check_output("rst_dq_oe",     32'(sram_dq_oe),  32'd0);
        check_output("rst_we_n",      32'(sram_we_n),   32'd1);
        check_output("rst_oe_n",      32'(sram_oe_n),   32'd1);
        rst = 1'b1;

        $display("[TB] directed writes and reads");
        apply_stimulus(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'd1024, 32'h0,        1'b0);
        apply_stimulus(1'b0, 1'b1, 32'd1032, 32'h0BAD_F00D, 1'b0);
        apply_stimulus(1'b0, 1'b1, 32'd1020, 32'h7777_1111, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'd1020, 32'h0,        1'b0);
        apply_stimulus(1'b1, 1'b0, 32'd1032, 32'h0,        1'b0);

        $display("[TB] reset in the middle of a write");
        sb_skip = 1'b1;
        @(posedge clk); #1;
        mif.wr_en      = 1'b1;
        mif.address    = 32'd1024;
        mif.write_data = 32'hA5A5_5A5A;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drop_request();
        @(posedge clk); #1;
        check_output("abort_we_n",      32'(sram_we_n),  32'd1);
        check_output("abort_dq_oe",     32'(sram_dq_oe), 32'd0);
        check_output("abort_ready",     32'(mif.ready),  32'd1);
        check_output("abort_read_data", mif.read_data,   32'h0);
        // The low-half strobe finished before reset, the high half never ran.
        ref_mem[0] = {ref_mem[0][31:16], 16'h5A5A};
        model_rd   = 32'h0;
        rst = 1'b1;
        @(posedge clk); #1;
        sb_skip = 1'b0;

        $display("[TB] both enables, held request, flush");
        apply_stimulus(1'b1, 1'b1, 32'd1028, 32'h1234_5678, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'd1028, 32'h0,        1'b0);

        @(posedge clk); #1;
        target         = done_count + 1;
        mif.wr_en      = 1'b1;
        mif.address    = 32'd1040;
        mif.write_data = 32'hCAFE_0042;
        push_expect(1'b0, 1'b1, 32'd1040, 32'hCAFE_0042, cycle_count);
        wait_done(target);
        #1;
        check_output("held_idle_ready", 32'(mif.ready), 32'd0);
        push_expect(1'b0, 1'b1, 32'd1040, 32'hCAFE_0042, cycle_count);
        wait_done(target + 1);
        #1;
        drop_request();

        apply_stimulus(1'b1, 1'b0, 32'd1024, 32'h0,        1'b1);
        apply_stimulus(1'b0, 1'b1, 32'd1044, 32'h600D_CAFE, 1'b1);
        apply_stimulus(1'b1, 1'b0, 32'd1044, 32'h0,        1'b0);
        apply_stimulus(1'b1, 1'b0, 32'd1040, 32'h0,        1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            int          kind;
            bit          rd;
            bit          wr;
            a    = ($urandom_range(0, 9) == 0) ? 32'd1020 : BASE + 32'($urandom_range(0, 15)) * 4;
            kind = $urandom_range(0, 3);
            rd   = (kind != 1);
            wr   = (kind == 1) || (kind == 2);
            apply_stimulus(rd, wr, a, $urandom, $urandom_range(0, 3) == 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check_output("pending_txns",   32'(exp_q.size()), 32'd0);
        check_output("pending_writes", 32'(wev_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
